// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t        : 2-bit sequencer state encoding
//   DEF_REG_ADDR_W : default register-index width
//   ZERO_REG       : index of the hard-wired zero register (never a real hazard)
//   CNT_BITS       : width of the internal multiply/drain down-counter
//   DRAIN_CNT      : counter preset on entry to DRAIN (gives four DRAIN cycles)
package pipeline_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG       = 0;
  localparam int CNT_BITS       = 4;

  localparam logic [CNT_BITS-1:0] DRAIN_CNT = 4'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   ex_mem_read       in  instruction in EX is a load
//   ex_rd             in  destination register of the instruction in EX
//   id_rs, id_rt      in  source registers of the instruction in ID
//   id_use_rs/rt      in  ID instruction actually reads rs/rt
//   luse              out ID must wait one cycle for the load result
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  output logic                  luse
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs && (id_rs == ex_rd);
  assign rt_hit = id_use_rt && (id_rt == ex_rd);

  // A load into the zero register never produces a value anyone waits for.
  assign luse = ex_mem_read && (ex_rd != REG_ADDR_W'(ZERO_REG)) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt   ID-stage source operands
//   ex_mem_read, ex_rd           EX-stage load and its destination
//   ex_is_mul                    EX holds a multi-cycle multiply (level)
//   ex_br_taken                  EX branch/jump resolved taken
//   dmem_busy                    data memory not ready: freeze everything
//   halt_req                     stop fetching and drain (level)
//   *_we                         stage register load enables
//   *_flush                      load a bubble instead of data (only with matching we=1)
//   halted                       pipeline drained and stopped
//   stall_cycles                 saturating count of cycles with pc_we=0 (RUN/MUL_WAIT)
//   state                        current sequencer state, for observation
// All enables/flushes are combinational from state and inputs; state and
// counters update on the rising edge.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_mul,
  input  logic                  ex_br_taken,
  input  logic                  dmem_busy,
  input  logic                  halt_req,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  idex_we,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [1:0]            state
);

  state_t              cur_state;
  state_t              nxt_state;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] nxt_cnt;
  logic                luse;
  logic                count_en;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .luse        (luse)
  );

  assign state = cur_state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RUN;
      cnt       <= '0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= nxt_cnt;
    end
  end

  // Next-state logic. dmem_busy freezes state and counter; HALTED only leaves on reset.
  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cnt;
    if (!dmem_busy) begin
      case (cur_state)
        ST_RUN: begin
          if (ex_is_mul) begin
            nxt_state = ST_MUL_WAIT;
            nxt_cnt   = CNT_BITS'(MUL_LAT - 2);
          end else if (!ex_br_taken && halt_req) begin
            // A taken branch on the halt cycle wins; halt is taken next cycle.
            nxt_state = ST_DRAIN;
            nxt_cnt   = DRAIN_CNT;
          end
        end
        ST_MUL_WAIT: begin
          if (cnt != '0) nxt_cnt = cnt - CNT_BITS'(1);
          else           nxt_state = ST_RUN;
        end
        ST_DRAIN: begin
          if (cnt != '0) nxt_cnt = cnt - CNT_BITS'(1);
          else           nxt_state = ST_HALTED;
        end
        default: ;
      endcase
    end
  end

  // Output logic, priority: halted > freeze > multiply > branch > halt/drain > load-use > run.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      if (cur_state == ST_HALTED) begin
        halted = 1'b1;
      end else if (dmem_busy) begin
        // freeze: everything stays 0
      end else if ((cur_state == ST_RUN && ex_is_mul) ||
                   (cur_state == ST_MUL_WAIT && cnt != '0)) begin
        // Multiply holds EX; a bubble flows on into MEM.
        exmem_we    = 1'b1;
        exmem_flush = 1'b1;
        memwb_we    = 1'b1;
      end else if (cur_state == ST_MUL_WAIT) begin
        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
      end else if (cur_state == ST_RUN && ex_br_taken) begin
        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (cur_state == ST_DRAIN || halt_req) begin
        // Stop fetching; feed bubbles into ID while older instructions retire.
        {ifid_we, idex_we, exmem_we, memwb_we} = 4'b1111;
        ifid_flush = 1'b1;
      end else if (luse) begin
        idex_we    = 1'b1;
        idex_flush = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
      end else begin
        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
      end
    end
  end

  assign count_en = (cur_state != ST_HALTED) && (cur_state != ST_DRAIN) && !pc_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (count_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_is_mul;
  logic        ex_br_taken;
  logic        dmem_busy;
  logic        halt_req;
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        halted;
  logic [31:0] stall_cycles;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Output vector: {pc,ifid,idex,exmem,memwb we, ifid,idex,exmem flush, halted}
  localparam logic [8:0] V_ZERO  = 9'b00000_000_0;
  localparam logic [8:0] V_RUN   = 9'b11111_000_0;
  localparam logic [8:0] V_LUSE  = 9'b00111_010_0;
  localparam logic [8:0] V_MUL   = 9'b00011_001_0;
  localparam logic [8:0] V_BR    = 9'b11111_110_0;
  localparam logic [8:0] V_DRAIN = 9'b01111_100_0;
  localparam logic [8:0] V_HALT  = 9'b00000_000_1;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_MULW   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  pipeline_ctrl #(.REG_ADDR_W(5), .MUL_LAT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_is_mul    (ex_is_mul),
    .ex_br_taken  (ex_br_taken),
    .dmem_busy    (dmem_busy),
    .halt_req     (halt_req),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [8:0] exp);
    #1;
    check(tag, 32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                    ifid_flush, idex_flush, exmem_flush, halted}), 32'(exp));
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_is_mul = 1'b0;
    ex_br_taken = 1'b0; dmem_busy = 1'b0; halt_req = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    ex_mem_read = 1'b1; ex_rd = rd;
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    // outputs held low during reset even with requests pending
    ex_is_mul = 1'b1; halt_req = 1'b1; ex_br_taken = 1'b1;
    check_outs("reset_outs", V_ZERO);
    tick();
    set_idle();
    rst = 1'b0;
    check("reset_state", 32'(state), 32'(S_RUN));
    check("reset_stall", stall_cycles, 32'd0);
    check_outs("run_idle", V_RUN);

    // load-use on rs: exactly one bubble
    set_load(5'd1, 5'd1, 1'b1, 5'd0, 1'b0);
    check_outs("luse_rs", V_LUSE);
    tick();
    set_idle();
    check_outs("luse_after", V_RUN);
    check("luse_stall", stall_cycles, 32'd1);
    tick();

    // load into r0: no hazard
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    check_outs("luse_r0", V_RUN);
    tick();
    // rs matches but is not read
    set_load(5'd3, 5'd3, 1'b0, 5'd4, 1'b1);
    check_outs("luse_unused", V_RUN);
    tick();
    // rt path
    set_load(5'd5, 5'd2, 1'b1, 5'd5, 1'b1);
    check_outs("luse_rt", V_LUSE);
    tick();
    set_idle();
    check("luse_rt_stall", stall_cycles, 32'd2);

    // multiply, MUL_LAT=4: three stall cycles then release
    ex_is_mul = 1'b1;
    check_outs("mul_c1", V_MUL);
    tick();
    check("mul_state", 32'(state), 32'(S_MULW));
    halt_req = 1'b1;   // deferred while in MUL_WAIT
    check_outs("mul_c2", V_MUL);
    tick();
    check_outs("mul_c3", V_MUL);
    tick();
    halt_req = 1'b0;   // ex_is_mul still high: ignored outside RUN
    check_outs("mul_release", V_RUN);
    tick();
    ex_is_mul = 1'b0;
    check("mul_stall", stall_cycles, 32'd5);
    check("mul_back_run", 32'(state), 32'(S_RUN));

    // multiply with two dmem_busy cycles inside MUL_WAIT
    ex_is_mul = 1'b1;
    check_outs("mulb_c1", V_MUL);
    tick();
    ex_is_mul = 1'b0;
    check_outs("mulb_c2", V_MUL);
    tick();
    dmem_busy = 1'b1;
    check_outs("mulb_busy1", V_ZERO);
    tick();
    check_outs("mulb_busy2", V_ZERO);
    tick();
    dmem_busy = 1'b0;
    check("mulb_hold", 32'(state), 32'(S_MULW));
    check_outs("mulb_c3", V_MUL);
    tick();
    check_outs("mulb_release", V_RUN);
    tick();
    check("mulb_stall", stall_cycles, 32'd10);

    // taken branch overrides load-use
    set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    ex_br_taken = 1'b1;
    check_outs("br_luse", V_BR);
    tick();
    set_idle();
    check("br_stall", stall_cycles, 32'd10);

    // branch on the halt cycle wins; halt follows
    ex_br_taken = 1'b1; halt_req = 1'b1;
    check_outs("br_halt", V_BR);
    tick();
    ex_br_taken = 1'b0;
    check("br_halt_state", 32'(state), 32'(S_RUN));
    check_outs("halt_c0", V_DRAIN);
    tick();
    check("drain_state", 32'(state), 32'(S_DRAIN));
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("drain_%0d", i), V_DRAIN);
      tick();
    end
    check("halted_state", 32'(state), 32'(S_HALTED));
    ex_br_taken = 1'b1; dmem_busy = 1'b1; ex_is_mul = 1'b1;
    check_outs("halted_outs", V_HALT);
    tick();
    check_outs("halted_hold", V_HALT);
    check("halted_stall", stall_cycles, 32'd11);

    // reset out of HALTED
    rst = 1'b1;
    check_outs("rst_halted", V_ZERO);
    tick();
    rst = 1'b0;
    set_idle();
    check("rst_state", 32'(state), 32'(S_RUN));
    check("rst_stall", stall_cycles, 32'd0);
    check_outs("rst_run", V_RUN);

    // reset aborts MUL_WAIT
    ex_is_mul = 1'b1;
    tick();
    ex_is_mul = 1'b0;
    check("abort_pre", 32'(state), 32'(S_MULW));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(state), 32'(S_RUN));
    check("abort_stall", stall_cycles, 32'd0);
    check_outs("abort_outs", V_RUN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
